// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use detection, MDU occupancy FSM,
// wrong-path squash on ID-resolved branches and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_wreg,
  input  logic [4:0]        ex_rd,
  input  logic              ex_is_load,
  input  logic              id_branch_taken,
  input  logic              id_mdu_start,
  input  logic              id_mdu_use,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              mdu_go,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MDU_LAT - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             lu;
  logic             mdu_stall;
  logic             stall;

  always_comb begin
    lu = ex_is_load & ex_wreg & (ex_rd != 5'd0) &
         ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
  end

  // Reset forces the pipeline to run freely, so every output is qualified by ~rst.
  assign mdu_busy    = ~rst & (state == BUSY);
  assign mdu_stall   = mdu_busy & (id_mdu_start | id_mdu_use);
  assign stall       = ~rst & (lu | mdu_stall);
  assign pc_en       = ~stall;
  assign if_id_en    = ~stall;
  assign id_ex_flush = stall;
  assign if_id_flush = ~rst & id_branch_taken & ~stall;
  assign mdu_go      = ~rst & (state == IDLE) & id_mdu_start & ~stall;
  assign mdu_done    = mdu_busy & (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu_go) begin
            state <= BUSY;
            cnt   <= LOAD_VAL;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule
